cm0_mtx_o_np: RTL

Parametrised N-input output stage for the Cortex-M0 AHB-Lite bus matrix. It routes one of NUM_PORTS input stages to a shared slave port and has an integrated registered round-robin arbiter. The arbiter holds the grant across burst continuations and locked sequences. The block tracks the data-phase owner for HWDATA/HWUSER muxing and generates HREADYMUXM from the slave's HREADYOUT. It sits between the input stages (one per master) and one slave region, replacing the single-port output stage plus its separate arbiter.

---
 rtl/cm0_mtx_o_np.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cm0_mtx_o_np.sv
// N-input AHB-Lite output stage for the Cortex-M0 bus matrix with an integrated registered arbiter.
// Define CM0_MTX_O_FIXED_PRI_EN for fixed lowest-index-wins priority; round-robin otherwise.
module cm0_mtx_o_np #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [NUM_PORTS-1:0]        sel_op,
  input  logic [NUM_PORTS-1:0]        held_tran_op,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_op,
  input  logic [NUM_PORTS*USER_W-1:0] auser_op,
  input  logic [NUM_PORTS*2-1:0]      trans_op,
  input  logic [NUM_PORTS-1:0]        write_op,
  input  logic [NUM_PORTS*3-1:0]      size_op,
  input  logic [NUM_PORTS*3-1:0]      burst_op,
  input  logic [NUM_PORTS*4-1:0]      prot_op,
  input  logic [NUM_PORTS*4-1:0]      master_op,
  input  logic [NUM_PORTS-1:0]        mastlock_op,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata_op,
  input  logic [NUM_PORTS*USER_W-1:0] wuser_op,
  input  logic                        HREADYOUTM,
  output logic [NUM_PORTS-1:0]        active_op,
  output logic                        HSELM,
  output logic [ADDR_W-1:0]           HADDRM,
  output logic [USER_W-1:0]           HAUSERM,
  output logic [1:0]                  HTRANSM,
  output logic                        HWRITEM,
  output logic [2:0]                  HSIZEM,
  output logic [2:0]                  HBURSTM,
  output logic [3:0]                  HPROTM,
  output logic [3:0]                  HMASTERM,
  output logic                        HMASTLOCKM,
  output logic [DATA_W-1:0]           HWDATAM,
  output logic [USER_W-1:0]           HWUSERM,
  output logic                        HREADYMUXM
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] req;
  logic [PORT_W-1:0]    addr_port;
  logic [PORT_W-1:0]    data_port;
  logic [PORT_W-1:0]    next_port;
  logic                 no_port;
  logic                 slave_sel;
  logic                 hsel_lock;
  logic                 hlock_arb;
  logic                 hold;
  logic                 any_req;

  assign req     = held_tran_op & sel_op;
  assign any_req = |req;

  // Handshake: HREADYMUXM is the shared ready. A transfer phase only advances on a
  // rising HCLK where HREADYMUXM=1; while it is 0 every register below holds its value.
  assign HREADYMUXM = slave_sel ? HREADYOUTM : 1'b1;

  // The grant is held across locked sequences and BUSY/SEQ burst continuations.
  assign hlock_arb = HMASTLOCKM & (hsel_lock | HSELM);
  assign hold      = !no_port & (hlock_arb | HTRANSM[0]);

`ifdef CM0_MTX_O_FIXED_PRI_EN
  always_comb begin
    next_port = addr_port;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) next_port = PORT_W'(i);
    end
  end
`else
  logic [PORT_W-1:0] last_grant;
  logic              rr_found;
  int                rr_idx;

  // Scan starts one past the previous winner so each requester waits at most NUM_PORTS-1 grants.
  always_comb begin
    next_port = addr_port;
    rr_found  = 1'b0;
    rr_idx    = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      rr_idx = (int'(last_grant) + k) % NUM_PORTS;
      if (!rr_found && req[PORT_W'(rr_idx)]) begin
        rr_found  = 1'b1;
        next_port = PORT_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_grant <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYMUXM && !hold && any_req) begin
      last_grant <= next_port;
    end
  end
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_port <= '0;
      no_port   <= 1'b1;
      data_port <= '0;
      slave_sel <= 1'b0;
      hsel_lock <= 1'b0;
    end else if (HREADYMUXM) begin
      data_port <= addr_port;
      slave_sel <= HSELM;
      if (HSELM && HTRANSM[1] && HMASTLOCKM) begin
        hsel_lock <= 1'b1;
      end else if (!HMASTLOCKM) begin
        hsel_lock <= 1'b0;
      end
      if (!hold) begin
        if (any_req) begin
          addr_port <= next_port;
          no_port   <= 1'b0;
        end else begin
          no_port   <= 1'b1;
        end
      end
    end
  end

  // Address/control mux; an unused encoding of addr_port leaves the outputs at X.
  always_comb begin
    active_op  = '0;
    HSELM      = 1'b0;
    HADDRM     = '0;
    HAUSERM    = '0;
    HTRANSM    = 2'b00;
    HWRITEM    = 1'b0;
    HSIZEM     = '0;
    HBURSTM    = '0;
    HPROTM     = '0;
    HMASTERM   = '0;
    HMASTLOCKM = 1'b0;
    if (!no_port) begin
      HSELM      = 1'bx;
      HADDRM     = 'x;
      HAUSERM    = 'x;
      HTRANSM    = 'x;
      HWRITEM    = 1'bx;
      HSIZEM     = 'x;
      HBURSTM    = 'x;
      HPROTM     = 'x;
      HMASTERM   = 'x;
      HMASTLOCKM = 1'bx;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (addr_port == PORT_W'(i)) begin
          active_op[i] = 1'b1;
          HSELM        = sel_op[i];
          HADDRM       = addr_op[i*ADDR_W +: ADDR_W];
          HAUSERM      = auser_op[i*USER_W +: USER_W];
          HTRANSM      = trans_op[i*2 +: 2];
          HWRITEM      = write_op[i];
          HSIZEM       = size_op[i*3 +: 3];
          HBURSTM      = burst_op[i*3 +: 3];
          HPROTM       = prot_op[i*4 +: 4];
          HMASTERM     = master_op[i*4 +: 4];
          HMASTLOCKM   = mastlock_op[i];
        end
      end
    end
  end

  always_comb begin
    HWDATAM = 'x;
    HWUSERM = 'x;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_port == PORT_W'(i)) begin
        HWDATAM = wdata_op[i*DATA_W +: DATA_W];
        HWUSERM = wuser_op[i*USER_W +: USER_W];
      end
    end
  end

endmodule
